decoder_5_to_32: RTL and testbench

DECODER_5_TO_32 -- requirements
Module: decoder_5_to_32

---
 rtl/decoder_5_to_32.sv | 59 +++++
 tb/tb_decoder_5_to_32.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/decoder_5_to_32.sv
// Registered 5-to-32 one-hot decoder with enable, valid flag and last-index capture.
// One-cycle latency from In/E to Out/Valid/Index; no backpressure, a new select is accepted every cycle.
module decoder_5_to_32 #(
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  In,
  input  logic        E,
  output logic [31:0] Out,
  output logic        Valid,
  output logic [4:0]  Index
);

  // XOR mask that turns an active-high one-hot into the configured polarity.
  localparam logic [31:0] INACTIVE = (ACTIVE_LOW != 0) ? 32'hFFFF_FFFF : 32'h0000_0000;

  logic [31:0] w_onehot;
  logic [31:0] w_next_out;
  logic [31:0] r_out;
  logic        r_valid;
  logic [4:0]  r_index;

  always_comb begin
    w_onehot = 32'h0000_0000;
    if (E) begin
      w_onehot[In] = 1'b1;
    end
    w_next_out = w_onehot ^ INACTIVE;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_out   <= INACTIVE;
      r_valid <= 1'b0;
      r_index <= 5'd0;
    end else begin
      r_out   <= w_next_out;
      r_valid <= E;
      if (E) begin
        r_index <= In;
      end
    end
  end

  assign Out   = r_out;
  assign Valid = r_valid;
  assign Index = r_index;

`ifndef SYNTHESIS
  // Exactly one active line while Valid, none otherwise.
  always @(negedge Clk) begin
    if (!Reset) begin
      assert (Valid ? ($countones(r_out ^ INACTIVE) == 1) : ((r_out ^ INACTIVE) == 32'h0));
    end
  end
`endif

endmodule

// File: tb/tb_decoder_5_to_32.sv
// Directed bench for decoder_5_to_32, both output polarities driven from shared inputs.
module tb_decoder_5_to_32;

  logic        Clk;
  logic        Reset;
  logic [4:0]  In;
  logic        E;
  logic [31:0] out_h;
  logic        valid_h;
  logic [4:0]  index_h;
  logic [31:0] out_l;
  logic        valid_l;
  logic [4:0]  index_l;

  int n_checks;
  int n_fails;

  decoder_5_to_32 #(.ACTIVE_LOW(0)) u_dut_h (
    .Clk(Clk), .Reset(Reset), .In(In), .E(E),
    .Out(out_h), .Valid(valid_h), .Index(index_h)
  );

  decoder_5_to_32 #(.ACTIVE_LOW(1)) u_dut_l (
    .Clk(Clk), .Reset(Reset), .In(In), .E(E),
    .Out(out_l), .Valid(valid_l), .Index(index_l)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    Reset = 1'b1;
    In    = 5'd0;
    E     = 1'b0;

    tick();
    tick();
    check_eq("rst_out_h", out_h, 32'h0000_0000);
    check_eq("rst_out_l", out_l, 32'hFFFF_FFFF);
    check_eq("rst_valid", {31'd0, valid_h}, 32'd0);
    check_eq("rst_index", {27'd0, index_h}, 32'd0);

    Reset = 1'b0;
    tick();
    check_eq("idle_out", out_h, 32'h0000_0000);
    check_eq("idle_valid", {31'd0, valid_h}, 32'd0);
    check_eq("idle_index", {27'd0, index_h}, 32'd0);

    In = 5'd1; E = 1'b1;
    tick();
    check_eq("in1_out", out_h, 32'h0000_0002);
    check_eq("in1_out_l", out_l, 32'hFFFF_FFFD);
    check_eq("in1_valid", {31'd0, valid_h}, 32'd1);
    check_eq("in1_index", {27'd0, index_h}, 32'd1);

    E = 1'b0;
    tick();
    check_eq("dis_out", out_h, 32'h0000_0000);
    check_eq("dis_out_l", out_l, 32'hFFFF_FFFF);
    check_eq("dis_valid", {31'd0, valid_h}, 32'd0);
    check_eq("dis_index_hold", {27'd0, index_h}, 32'd1);

    // Back-to-back selects with E held high.
    E = 1'b1; In = 5'd9;
    tick();
    check_eq("b2b_9", out_h, 32'h0000_0200);
    In = 5'd17;
    tick();
    check_eq("b2b_17", out_h, 32'h0002_0000);
    In = 5'd25;
    tick();
    check_eq("b2b_25", out_h, 32'h0200_0000);
    check_eq("b2b_index", {27'd0, index_h}, 32'd25);

    for (int i = 0; i < 32; i++) begin
      In = 5'(i);
      tick();
      check_eq($sformatf("sweep_%0d", i), out_h, 32'd1 << i);
      check_eq($sformatf("sweep_l_%0d", i), out_l, ~(32'd1 << i));
      check_eq($sformatf("sweep_ones_%0d", i), 32'($countones(out_h)), 32'd1);
    end
    check_eq("sweep_31", out_h, 32'h8000_0000);
    check_eq("sweep_31_index", {27'd0, index_h}, 32'd31);

    In = 5'd3;
    tick();
    check_eq("al_in3", out_l, 32'hFFFF_FFF7);
    check_eq("ah_in3", out_h, 32'h0000_0008);

    // Index must hold while disabled, regardless of In.
    In = 5'd20; E = 1'b0;
    tick();
    check_eq("hold_index", {27'd0, index_h}, 32'd3);
    check_eq("hold_out", out_h, 32'h0000_0000);

    // Asynchronous reset in the middle of an active decode.
    In = 5'd1; E = 1'b1;
    tick();
    check_eq("pre_arst_out", out_h, 32'h0000_0002);
    #2;
    Reset = 1'b1;
    #1;
    check_eq("arst_out_h", out_h, 32'h0000_0000);
    check_eq("arst_out_l", out_l, 32'hFFFF_FFFF);
    check_eq("arst_valid", {31'd0, valid_h}, 32'd0);
    check_eq("arst_index", {27'd0, index_h}, 32'd0);

    // Reset wins over an enabled select across a clock edge.
    tick();
    check_eq("rst_prio_out", out_h, 32'h0000_0000);
    check_eq("rst_prio_valid", {31'd0, valid_h}, 32'd0);

    In = 5'd7;
    Reset = 1'b0;
    tick();
    check_eq("post_rst_out", out_h, 32'h0000_0080);
    check_eq("post_rst_out_l", out_l, 32'hFFFF_FF7F);
    check_eq("post_rst_valid", {31'd0, valid_l}, 32'd1);
    check_eq("post_rst_index", {27'd0, index_l}, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
